// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader and its neighbours on the bus.
// State codes and strobe polarity are common to control_block and the top level.
package program_loader_pkg;

    localparam int RAM_BYTES_DEF = 16;
    localparam int ADDR_W_DEF    = 4;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_REL   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_WAIT  = ST_WAIT,
        S_ADDR  = ST_ADDR,
        S_DATA  = ST_DATA,
        S_WRITE = ST_WRITE,
        S_REL   = ST_REL,
        S_DONE  = ST_DONE
    } load_state_t;

endpackage

// File: rtl/program_loader.sv
// Loads RAM one host byte at a time through the shared bus while in
// programming mode; Moore FSM, outputs decoded from state and address only.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int RAM_BYTES = RAM_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              programming,
    input  logic              host_valid,
    output logic              ready,
    output logic              busy,
    output logic              addr_oe,
    output logic [ADDR_W-1:0] addr,
    output logic              read_ui_in,
    output logic              nLma,
    output logic              nLmd,
    output logic              nLr,
    output logic              done_load
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

    load_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Dropping programming aborts any load; a partial RAM image is kept.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (!programming) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT;
                    addr_d  = '0;
                end
                S_WAIT: begin
                    if (host_valid) state_d = S_ADDR;
                end
                S_ADDR:  state_d = S_DATA;
                S_DATA:  state_d = S_WRITE;
                S_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_REL;
                    end
                end
                S_REL: begin
                    if (!host_valid) state_d = S_WAIT;
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready      = 1'b0;
        busy       = 1'b1;
        addr_oe    = 1'b0;
        read_ui_in = 1'b0;
        nLma       = STROBE_OFF;
        nLmd       = STROBE_OFF;
        nLr        = STROBE_OFF;
        done_load  = 1'b0;
        unique case (state_q)
            S_IDLE:  busy = 1'b0;
            S_WAIT:  ready = 1'b1;
            S_ADDR: begin
                addr_oe = 1'b1;
                nLma    = STROBE_ON;
            end
            S_DATA: begin
                read_ui_in = 1'b1;
                nLmd       = STROBE_ON;
            end
            S_WRITE: nLr = STROBE_ON;
            S_REL:   busy = 1'b1;
            S_DONE: begin
                busy      = 1'b0;
                done_load = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    assign addr = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: models bus, MAR, MDR and RAM around the DUT and
// scoreboards every RAM write against the bytes the host presented.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       programming = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic       ready, busy, addr_oe, read_ui_in;
    logic       nLma, nLmd, nLr, done_load;
    logic [3:0] addr;

    logic [7:0]  bus;
    logic [3:0]  mar = 4'h0;
    logic [7:0]  mdr = 8'h00;
    logic [7:0]  ram [16];
    logic [11:0] sb_q [$];
    logic [3:0]  exp_addr = 4'h0;

    int n_pass = 0;
    int n_total = 0;

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .programming(programming),
        .host_valid(host_valid), .ready(ready), .busy(busy),
        .addr_oe(addr_oe), .addr(addr), .read_ui_in(read_ui_in),
        .nLma(nLma), .nLmd(nLmd), .nLr(nLr), .done_load(done_load)
    );

    always #5 clk = ~clk;

    assign bus = addr_oe ? {4'h0, addr} : (read_ui_in ? ui_in : 8'h00);

    always @(posedge clk) begin
        if (nLma === 1'b0) mar <= bus[3:0];
        if (nLmd === 1'b0) mdr <= bus;
        if (nLr === 1'b0) ram[mar] <= mdr;
    end

    // Bus exclusivity and write scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        int lows;
        logic [11:0] e;
        lows = (nLma === 1'b0) + (nLmd === 1'b0) + (nLr === 1'b0);
        n_total++;
        if (addr_oe === 1'b1 && read_ui_in === 1'b1)
            $display("FAIL bus_excl: addr_oe=1 read_ui_in=1 want not both");
        else n_pass++;
        n_total++;
        if (lows > 1) $display("FAIL strobe_excl: %0d low want <=1", lows);
        else n_pass++;
        if (nLr === 1'b0) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_write: mar=%h mdr=%h want none", mar, mdr);
            end else begin
                e = sb_q.pop_front();
                if ({mar, mdr} !== e)
                    $display("FAIL write: addr/data=%h/%h want %h/%h",
                             mar, mdr, e[11:8], e[7:0]);
                else n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_total++;
        if (ready !== 1'b1) $display("FAIL %s_ready: ready=%b want 1", tag, ready);
        else n_pass++;
    endtask

    task automatic send_byte(input logic [7:0] d);
        wait_ready("send");
        ui_in = d;
        host_valid = 1'b1;
        sb_q.push_back({exp_addr, d});
        tick();
        host_valid = 1'b0;
        n_total++;
        if ({ready, addr_oe, nLma, bus} !== {3'b010, 4'h0, exp_addr})
            $display("FAIL addr_phase: rdy/oe/nLma/bus=%b%b%b/%h want 010/%h",
                     ready, addr_oe, nLma, bus, {4'h0, exp_addr});
        else n_pass++;
        tick();
        n_total++;
        if ({read_ui_in, nLmd, bus} !== {2'b10, d})
            $display("FAIL data_phase: rd/nLmd/bus=%b%b/%h want 10/%h",
                     read_ui_in, nLmd, bus, d);
        else n_pass++;
        tick();
        n_total++;
        if ({nLr, nLma, nLmd, ready} !== 4'b0110)
            $display("FAIL write_phase: nLr/nLma/nLmd/rdy=%b%b%b%b want 0110",
                     nLr, nLma, nLmd, ready);
        else n_pass++;
        tick();
        if (exp_addr != 4'hF) exp_addr++;
    endtask

    task automatic restart();
        programming = 1'b0;
        tick();
        exp_addr = 4'h0;
        programming = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        programming = 1'b1;
        tick();
        host_valid = 1'b1;
        tick();
        n_total++;
        if (addr_oe !== 1'b1) $display("FAIL reset_pre: addr_oe=%b want 1", addr_oe);
        else n_pass++;
        rst_n = 1'b0;
        host_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if ({ready, busy, addr_oe, read_ui_in, nLma, nLmd, nLr, done_load, addr}
                !== {8'b0000_1110, 4'h0})
                $display("FAIL reset_state: outs=%b%b%b%b%b%b%b%b addr=%h want 00001110 0",
                         ready, busy, addr_oe, read_ui_in, nLma, nLmd, nLr,
                         done_load, addr);
            else n_pass++;
        end
        programming = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        restart();
        send_byte(8'hA5);
        n_total++;
        if (ram[0] !== 8'hA5) $display("FAIL single_ram0: got %h want a5", ram[0]);
        else n_pass++;
    endtask

    task automatic test_full_load();
        int strobes = 0;
        restart();
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        n_total++;
        if ({done_load, busy, ready} !== 3'b100)
            $display("FAIL full_done: done/busy/rdy=%b%b%b want 100",
                     done_load, busy, ready);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (ram[i] !== 8'h10 + 8'(i))
                $display("FAIL full_ram%0d: got %h want %h", i, ram[i], 8'h10 + 8'(i));
            else n_pass++;
        end
        ui_in = 8'hEE;
        host_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (nLma === 1'b0 || nLmd === 1'b0 || nLr === 1'b0 ||
                addr_oe === 1'b1 || read_ui_in === 1'b1) strobes++;
        end
        host_valid = 1'b0;
        n_total++;
        if (strobes != 0) $display("FAIL extra_byte: %0d strobe cycles want 0", strobes);
        else n_pass++;
        n_total++;
        if ({done_load, addr} !== {1'b1, 4'hF})
            $display("FAIL done_hold: done=%b addr=%h want 1 f", done_load, addr);
        else n_pass++;
        programming = 1'b0;
        tick();
        n_total++;
        if ({done_load, addr, busy} !== {1'b0, 4'h0, 1'b0})
            $display("FAIL done_exit: done=%b addr=%h busy=%b want 0 0 0",
                     done_load, addr, busy);
        else n_pass++;
    endtask

    task automatic test_handshake_hold();
        int writes = 0;
        int rdy_hi = 0;
        restart();
        wait_ready("hold");
        ui_in = 8'h77;
        host_valid = 1'b1;
        sb_q.push_back({4'h0, 8'h77});
        for (int i = 0; i < 10; i++) begin
            tick();
            if (nLr === 1'b0) writes++;
            if (ready !== 1'b0) rdy_hi++;
        end
        host_valid = 1'b0;
        n_total++;
        if (writes != 1) $display("FAIL hold_writes: got %0d want 1", writes);
        else n_pass++;
        n_total++;
        if (rdy_hi != 0) $display("FAIL hold_ready: high %0d cycles want 0", rdy_hi);
        else n_pass++;
        n_total++;
        if (ram[0] !== 8'h77) $display("FAIL hold_ram0: got %h want 77", ram[0]);
        else n_pass++;
        exp_addr = 4'h1;
        wait_ready("hold_rel");
    endtask

    task automatic test_abort();
        restart();
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
        programming = 1'b0;
        tick();
        n_total++;
        if ({busy, ready, done_load, addr} !== {3'b000, 4'h0})
            $display("FAIL abort_idle: busy/rdy/done=%b%b%b addr=%h want 000 0",
                     busy, ready, done_load, addr);
        else n_pass++;
        exp_addr = 4'h0;
        programming = 1'b1;
        tick();
        send_byte(8'h5A);
        n_total++;
        if ({ram[0], ram[1], ram[4]} !== {8'h5A, 8'hC1, 8'hC4})
            $display("FAIL abort_ram: got %h %h %h want 5a c1 c4",
                     ram[0], ram[1], ram[4]);
        else n_pass++;
        programming = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        test_reset();
        test_single();
        test_full_load();
        test_handshake_hold();
        test_abort();
        repeat (3) tick();
        n_total++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: %0d pending want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
